// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter sharing one I2C master between two requesters
module i2c_arbiter #(
    parameter int TIMEOUT        = 4096,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_rw,
    input  logic [6:0]  req0_addr,
    input  logic [7:0]  req0_wdata,
    input  logic        req0_speed,
    output logic        req0_done,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic        req1_rw,
    input  logic [6:0]  req1_addr,
    input  logic [7:0]  req1_wdata,
    input  logic        req1_speed,
    output logic        req1_done,
    output logic        req1_err,
    output logic [7:0]  rdata,
    output logic        grant_id,
    output logic        busy,
    output logic [31:0] i2c_command,
    output logic [31:0] i2c_dataIn,
    input  logic [31:0] i2c_dataOut
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, COMPLETE, RECOVER} state_t;

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);
    localparam logic [15:0] RC_LAST  = 16'(RECOVER_CYCLES - 1);

    state_t      state;
    logic        last_grant;
    logic        lat_rw;
    logic [6:0]  lat_addr;
    logic [7:0]  lat_wdata;
    logic        cmd_start;
    logic        cmd_reset;
    logic        cmd_speed;
    logic [15:0] wdog;
    logic [15:0] rcnt;
    logic        pick;
    logic        ready;
    logic [15:0] wdog_inc;
    logic        unused_dataout;

    assign ready          = i2c_dataOut[8];
    assign unused_dataout = &{1'b0, i2c_dataOut[31:9]};
    assign wdog_inc       = (wdog == 16'hFFFF) ? wdog : wdog + 16'd1;
    assign i2c_command    = {29'b0, cmd_speed, cmd_reset, cmd_start};
    assign i2c_dataIn     = {16'b0, lat_wdata, lat_addr, lat_rw};

    // A tie goes to whoever was not served last; otherwise the lone requester wins.
    always_comb begin
        pick = req1_valid;
        if (req0_valid && req1_valid) begin
            pick = ~last_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            lat_rw     <= 1'b0;
            lat_addr   <= 7'd0;
            lat_wdata  <= 8'd0;
            cmd_start  <= 1'b0;
            cmd_reset  <= 1'b0;
            cmd_speed  <= 1'b0;
            wdog       <= 16'd0;
            rcnt       <= 16'd0;
            rdata      <= 8'd0;
            busy       <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            req0_err  <= 1'b0;
            req1_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        grant_id  <= pick;
                        lat_rw    <= pick ? req1_rw    : req0_rw;
                        lat_addr  <= pick ? req1_addr  : req0_addr;
                        lat_wdata <= pick ? req1_wdata : req0_wdata;
                        cmd_speed <= pick ? req1_speed : req0_speed;
                        cmd_start <= 1'b0;
                        cmd_reset <= 1'b0;
                        wdog      <= 16'd0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wdog == WD_LIMIT) begin
                        cmd_start <= 1'b0;
                        cmd_reset <= 1'b1;
                        cmd_speed <= 1'b0;
                        rcnt      <= 16'd0;
                        state     <= RECOVER;
                    end else if (cmd_start && !ready) begin
                        // Master has accepted the start; stop requesting it.
                        cmd_start <= 1'b0;
                        wdog      <= 16'd0;
                        state     <= WAIT_DONE;
                    end else begin
                        cmd_start <= 1'b1;
                        wdog      <= wdog_inc;
                    end
                end
                WAIT_DONE: begin
                    if (wdog == WD_LIMIT) begin
                        cmd_reset <= 1'b1;
                        cmd_speed <= 1'b0;
                        rcnt      <= 16'd0;
                        state     <= RECOVER;
                    end else if (ready) begin
                        if (lat_rw) begin
                            rdata <= i2c_dataOut[7:0];
                        end
                        req0_done <= ~grant_id;
                        req1_done <= grant_id;
                        state     <= COMPLETE;
                    end else begin
                        wdog <= wdog_inc;
                    end
                end
                COMPLETE: begin
                    last_grant <= grant_id;
                    cmd_speed  <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                RECOVER: begin
                    if (rcnt == RC_LAST) begin
                        cmd_reset  <= 1'b0;
                        req0_err   <= ~grant_id;
                        req1_err   <= grant_id;
                        last_grant <= grant_id;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        rcnt <= rcnt + 16'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - self-checking bench for i2c_arbiter
module tb_i2c_arbiter;

    localparam int WD_T = 16;
    localparam int RC_N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 0, req0_rw = 0, req0_speed = 0;
    logic [6:0]  req0_addr = 0;
    logic [7:0]  req0_wdata = 0;
    logic        req1_valid = 0, req1_rw = 0, req1_speed = 0;
    logic [6:0]  req1_addr = 0;
    logic [7:0]  req1_wdata = 0;
    logic        req0_done, req0_err, req1_done, req1_err, grant_id, busy;
    logic [7:0]  rdata;
    logic [31:0] i2c_command, i2c_dataIn;
    logic [31:0] i2c_dataOut = 32'h100;

    logic        w_done0, w_err0, w_done1, w_err1, w_grant, w_busy;
    logic [7:0]  w_rdata;
    logic [31:0] w_cmd, w_din;
    logic [31:0] w_dout = 32'h100;

    always #31 clk = ~clk;

    i2c_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_speed(req0_speed),
        .req0_done(req0_done), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_speed(req1_speed),
        .req1_done(req1_done), .req1_err(req1_err),
        .rdata(rdata), .grant_id(grant_id), .busy(busy),
        .i2c_command(i2c_command), .i2c_dataIn(i2c_dataIn), .i2c_dataOut(i2c_dataOut)
    );

    i2c_arbiter #(.TIMEOUT(WD_T), .RECOVER_CYCLES(RC_N)) dut_wd (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_speed(req0_speed),
        .req0_done(w_done0), .req0_err(w_err0),
        .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_speed(req1_speed),
        .req1_done(w_done1), .req1_err(w_err1),
        .rdata(w_rdata), .grant_id(w_grant), .busy(w_busy),
        .i2c_command(w_cmd), .i2c_dataIn(w_din), .i2c_dataOut(w_dout)
    );

    int total = 0;
    int bad = 0;
    int n_pulse = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Master model: ready drops m_drop cycles after start, returns m_busy cycles later with m_rd.
    int         m_phase = 0, m_cnt = 0, m_drop = 2, m_busy = 40;
    logic [7:0] m_rd = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            m_phase = 0;
            i2c_dataOut = 32'h100;
        end else begin
            case (m_phase)
                0: if (i2c_command[0]) begin m_cnt = m_drop; m_phase = 1; end
                1: begin
                    m_cnt--;
                    if (m_cnt <= 0) begin i2c_dataOut = 32'h0EE; m_cnt = m_busy; m_phase = 2; end
                end
                default: begin
                    m_cnt--;
                    if (m_cnt <= 0) begin i2c_dataOut = {23'b0, 1'b1, m_rd}; m_phase = 0; end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            int s;
            s = int'(req0_done) + int'(req1_done) + int'(req0_err) + int'(req1_err);
            if (s > 0) n_pulse++;
            chk("single_pulse", s <= 1, 1);
        end
    end

    task automatic wait_start();
        int c = 0;
        while (!i2c_command[0] && c < 100) begin @(negedge clk); c++; end
        chk("start_seen", i2c_command[0], 1);
    endtask

    task automatic wait_fall();
        int c = 0;
        while (i2c_command[0] && c < 100) begin @(negedge clk); c++; end
        chk("start_fall", i2c_command[0], 0);
    endtask

    task automatic wait_pulse();
        int c = 0;
        while (!(req0_done || req1_done || req0_err || req1_err) && c < 400) begin
            @(negedge clk); c++;
        end
        chk("pulse_seen", req0_done | req1_done | req0_err | req1_err, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cmd"}, i2c_command, 0);
        chk({tag, "_din"}, i2c_dataIn, 0);
        chk({tag, "_rdata"}, {24'b0, rdata}, 0);
        chk({tag, "_flags"}, {grant_id, busy, req0_done, req1_done, req0_err, req1_err}, 0);
    endtask

    typedef struct {
        logic v0, v1;
        logic rw0; logic [6:0] a0; logic [7:0] w0; logic s0;
        logic rw1; logic [6:0] a1; logic [7:0] w1; logic s1;
        logic [7:0] rd; logic eg; logic [31:0] edin; logic [31:0] ecmd; logic [7:0] erd;
    } vec_t;
    vec_t tbl[5];

    logic       t_rw[2], t_speed[2];
    logic [6:0] t_addr[2];
    logic [7:0] t_wdata[2];

    task automatic drive(input int r, input logic v);
        if (r == 0) begin
            req0_valid = v; req0_rw = t_rw[0]; req0_addr = t_addr[0];
            req0_wdata = t_wdata[0]; req0_speed = t_speed[0];
        end else begin
            req1_valid = v; req1_rw = t_rw[1]; req1_addr = t_addr[1];
            req1_wdata = t_wdata[1]; req1_speed = t_speed[1];
        end
    endtask

    task automatic scramble(input logic g);
        if (!g) begin
            req0_valid = 0; req0_rw = ~req0_rw; req0_addr = ~req0_addr;
            req0_wdata = ~req0_wdata; req0_speed = ~req0_speed;
        end else begin
            req1_valid = 0; req1_rw = ~req1_rw; req1_addr = ~req1_addr;
            req1_wdata = ~req1_wdata; req1_speed = ~req1_speed;
        end
    endtask

    initial begin
        logic       mlast, e;
        logic [7:0] exp_rd;
        int         pc;
        int         rec_start, rec_end;

        tbl[0] = '{1, 0, 0, 7'h50, 8'hA5, 1, 0, 7'h00, 8'h00, 0, 8'h00, 0, 32'h0000A5A0, 32'h5, 8'h00};
        tbl[1] = '{0, 1, 0, 7'h00, 8'h00, 0, 1, 7'h48, 8'h00, 0, 8'h3C, 1, 32'h00000091, 32'h1, 8'h3C};
        tbl[2] = '{1, 1, 1, 7'h7F, 8'hFF, 0, 1, 7'h48, 8'h00, 0, 8'h81, 0, 32'h0000FFFF, 32'h1, 8'h81};
        tbl[3] = '{1, 1, 0, 7'h00, 8'h00, 0, 0, 7'h01, 8'h12, 1, 8'h55, 1, 32'h00001202, 32'h5, 8'h81};
        tbl[4] = '{1, 1, 0, 7'h00, 8'h00, 0, 1, 7'h33, 8'h44, 1, 8'h99, 0, 32'h00000000, 32'h1, 8'h81};

        // Reset state with requests already pending.
        req0_valid = 1; req1_valid = 1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 0;

        for (int i = 0; i < 5; i++) begin
            req0_valid = tbl[i].v0; req0_rw = tbl[i].rw0; req0_addr = tbl[i].a0;
            req0_wdata = tbl[i].w0; req0_speed = tbl[i].s0;
            req1_valid = tbl[i].v1; req1_rw = tbl[i].rw1; req1_addr = tbl[i].a1;
            req1_wdata = tbl[i].w1; req1_speed = tbl[i].s1;
            m_rd = tbl[i].rd; m_drop = 2; m_busy = 40;
            wait_start();
            chk($sformatf("tbl%0d_grant", i), grant_id, tbl[i].eg);
            chk($sformatf("tbl%0d_din", i), i2c_dataIn, tbl[i].edin);
            chk($sformatf("tbl%0d_cmd", i), i2c_command, tbl[i].ecmd);
            chk($sformatf("tbl%0d_busy", i), busy, 1);
            scramble(tbl[i].eg);
            wait_fall();
            chk($sformatf("tbl%0d_cmd_wait", i), i2c_command, tbl[i].ecmd & 32'hFFFF_FFFE);
            chk($sformatf("tbl%0d_din_hold", i), i2c_dataIn, tbl[i].edin);
            wait_pulse();
            chk($sformatf("tbl%0d_done", i), {req1_done, req0_done}, tbl[i].eg ? 2'b10 : 2'b01);
            chk($sformatf("tbl%0d_err", i), {req1_err, req0_err}, 0);
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].erd);
        end

        // Randomised: both requesters always pending, so service must alternate.
        mlast = tbl[4].eg;
        exp_rd = tbl[4].erd;
        for (int r = 0; r < 2; r++) begin
            t_rw[r] = 1'($urandom); t_addr[r] = 7'($urandom);
            t_wdata[r] = 8'($urandom); t_speed[r] = 1'($urandom);
            drive(r, 1);
        end
        for (int n = 0; n < 16; n++) begin
            e = ~mlast;
            m_rd = 8'($urandom); m_drop = $urandom_range(1, 4); m_busy = $urandom_range(1, 12);
            wait_start();
            chk("rnd_grant", grant_id, e);
            chk("rnd_din", i2c_dataIn,
                (32'(t_wdata[e]) << 8) + (32'(t_addr[e]) << 1) + 32'(t_rw[e]));
            chk("rnd_speed", i2c_command[2], t_speed[e]);
            if ($urandom_range(0, 1) == 1) scramble(e);
            if (t_rw[e]) exp_rd = m_rd;
            wait_pulse();
            chk("rnd_done", {req1_done, req0_done}, e ? 2'b10 : 2'b01);
            chk("rnd_err", {req1_err, req0_err}, 0);
            chk("rnd_rdata", rdata, exp_rd);
            mlast = e;
            t_rw[e] = 1'($urandom); t_addr[e] = 7'($urandom);
            t_wdata[e] = 8'($urandom); t_speed[e] = 1'($urandom);
            drive(int'(e), 1);
            @(negedge clk);
            chk("rnd_idle_gap", busy, 0);
            @(negedge clk);
            chk("rnd_regrant", busy, 1);
        end

        // Watchdog on the short-timeout instance: its master never drops ready.
        rst = 1; req0_valid = 0; req1_valid = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        req0_valid = 1; req0_rw = 0; req0_speed = 0; req0_addr = 7'h10; req0_wdata = 8'h20;
        rec_start = 1 + WD_T;
        rec_end = rec_start + RC_N;
        for (int i = 1; i <= rec_end + 1; i++) begin
            @(negedge clk);
            chk($sformatf("wd_cmd_%0d", i), w_cmd,
                (i >= rec_start && i < rec_end) ? 32'h2 : ((i >= 2 && i < rec_start) ? 32'h1 : 32'h0));
            chk($sformatf("wd_err_%0d", i), {w_err1, w_err0}, (i == rec_end) ? 2'b01 : 2'b00);
            chk($sformatf("wd_done_%0d", i), {w_done1, w_done0}, 0);
            chk($sformatf("wd_busy_%0d", i), w_busy, (i < rec_end) ? 1 : 0);
            if (i == rec_end) req0_valid = 0;
        end

        // Reset mid-WAIT_DONE, then a tie must go to req0.
        rst = 1; req0_valid = 0; req1_valid = 0;
        m_drop = 2; m_busy = 40;
        repeat (2) @(negedge clk);
        rst = 0;
        req0_valid = 1; req0_rw = 1; req0_addr = 7'h22; req0_wdata = 8'h00; req0_speed = 1;
        req1_valid = 1; req1_rw = 0; req1_addr = 7'h23; req1_wdata = 8'h77; req1_speed = 0;
        wait_start();
        wait_fall();
        repeat (3) @(negedge clk);
        pc = n_pulse;
        rst = 1;
        @(negedge clk);
        check_zero("midrst");
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 1);
        chk("rst_cmd_k1", i2c_command, 32'h4);
        @(negedge clk);
        chk("rst_cmd_k2", i2c_command, 32'h5);
        chk("rst_no_pulse", n_pulse, pc);
        m_rd = 8'h6B;
        wait_pulse();
        chk("rst_done", {req1_done, req0_done}, 2'b01);
        chk("rst_rdata", rdata, 8'h6B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
